valu_issue_arbiter: RTL
=======================

# valu_issue_arbiter

Round-robin issue controller sharing one `vector_alu` (THREADS lanes) among WARPS warp requesters in the SIMD/SIMT core. Grants one warp per cycle and drives the ALU lanes with that warp's operands, forcing inactive lanes to a benign op. It captures the combinational ALU results into a one-entry response buffer with per-lane masked flags. The buffer has valid/ready backpressure towards writeback/branch logic.

## Interface
- `THREADS`, 4, lanes per warp (= vector_alu lanes)
- `WARPS`, 4, requesting warps; power of two, ≥2
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  asynchronous reset, active-high
- `req_valid`  in  WARPS  warp w has an ALU op pending
- `req_ready`  out  WARPS  one-hot or zero; transfer for w when `req_valid[w] & req_ready[w]`
- `req_op`  in  WARPS x aluop_t  op, uniform across lanes of a warp
- `req_porta`, `req_portb`  in  WARPS x THREADS x word_t  lane operands
- `req_mask`  in  WARPS x THREADS  active-thread mask
- `alu_op`  out  THREADS x aluop_t  to vector_alu
- `alu_porta`, `alu_portb`  out  THREADS x word_t  to vector_alu
- `alu_out`  in  THREADS x word_t  from vector_alu (combinational)
- `alu_nf`, `alu_zf`, `alu_of`  in  THREADS  per-lane flags from vector_alu
- `rsp_valid`  out  1  response buffer full
- `rsp_ready`  in  1  consumer accepts response this cycle
- `rsp_warp`  out  warp_id_t  warp that issued the op
- `rsp_out`  out  THREADS x word_t  lane results; inactive lanes 0
- `rsp_mask`  out  THREADS  issued mask
- `rsp_zmask`, `rsp_nmask`  out  THREADS  `zf & mask`, `nf & mask` per lane
- `rsp_ovf`  out  1  OR over lanes of `of & mask`

## Operation
- FSM states: `EMPTY` (no held response) and `FULL` (`rsp_valid`=1).
- `accept = (state==EMPTY) | rsp_ready`.
- Arbitration: round-robin over `req_valid`, searching from `rr_ptr` upward with wrap. Winner g gets `req_ready[g] = accept`; all other ready bits are 0. With no valid requests, all ready bits are 0.
- `rr_ptr` updates to `(g+1) mod WARPS` only on a transfer. It holds when `accept`=0 or when no request is valid.
- ALU drive in the transfer cycle, lane i active (`req_mask[g][i]`=1): `alu_op[i]=req_op[g]`, ports = warp g operands.
- ALU drive for lane i inactive, and for all lanes when there is no transfer: `alu_op[i]=ALU_ADD`, ports 0, so the flags are deterministic.
- Capture on transfer:
  - `rsp_out[i] = mask[i] ? alu_out[i] : 0`.
  - `rsp_zmask`/`rsp_nmask` are masked per lane.
  - `rsp_ovf` is the masked OR of `alu_of`.
  - `rsp_warp = g`.
  - State goes to `FULL`.
- `FULL` & `rsp_ready` & no transfer: state goes to `EMPTY`. Data fields are retained but are don't-care.
- `FULL` & `rsp_ready` & transfer: the buffer is overwritten the same cycle and stays `FULL`.
- `FULL` & `!rsp_ready`: outputs are frozen and all `req_ready` bits are 0.
- All-zero `req_mask` is legal. It is accepted, and its response has `rsp_mask`=0, `rsp_out`=0, zmask/nmask=0, ovf=0.
- Requester rule: once `req_valid[w]` is asserted, operands, op and mask are held and valid is not dropped until transfer. The bench asserts this.
- Arithmetic/width: no width change. ALU results pass through unmodified for active lanes.

## Timing
- `req_ready` is combinational from `req_valid`, `rr_ptr`, state and `rsp_ready`. There is no combinational path from any `req_*` data input to any `rsp_*` output.
- Latency: transfer in cycle N → `rsp_valid`=1 with that data in cycle N+1.
- Throughput: one op per cycle while `rsp_ready`=1.
- Reset (async assert, synchronous-safe deassert):
  - state=`EMPTY`, `rr_ptr`=0.
  - `rsp_valid`=0, `rsp_warp`=0, `rsp_out`=0, `rsp_mask`=0, `rsp_zmask`=0, `rsp_nmask`=0, `rsp_ovf`=0.
- Reset mid-operation discards a held response. No partial transfer is reported.
- Response ordering equals grant order.
- Starvation bound: a continuously valid warp is granted within WARPS transfers.

## Structure
- `cpu_types_pkg` additions:
  - `warp_id_t` (`$clog2(WARPS)` bits)
  - `thread_mask_t`
  - `valu_state_t` enum {`EMPTY`, `FULL`}
  - `ALU_ADD` as the idle op (reuse the existing `aluop_t`)
- Sub-module `rr_arbiter` (param N). Inputs: `req[N]`, `ptr`. Outputs: one-hot `gnt`, `gnt_idx`, `any`. It is purely combinational; `rr_ptr` lives in the parent.
- `vector_alu` is instantiated beside this block, not inside it.

## Test plan
- Reset:
  - Stimulus: assert `RST` mid-stream with `rsp_valid`=1.
  - Required: `rsp_valid`=0 and all `rsp_*`=0 immediately.
  - Required: after release, the first grant goes to warp 0 when all warps are requesting.
- Round-robin fairness:
  - Stimulus: `req_valid`=4'b1111 held, `rsp_ready`=1.
  - Required: grants 0,1,2,3,0,… on consecutive cycles, and `rsp_warp` follows one cycle later.
- Masked lanes:
  - Stimulus: warp 2, op ADD, porta={1,2,3,4}, portb={10,20,30,40}, mask=4'b0101.
  - Required: `rsp_out`={11,0,33,0}, `rsp_mask`=4'b0101, `rsp_ovf`=0.
- Flag masking:
  - Stimulus: warp 1, SUB with porta=portb=5 on all lanes, mask=4'b0011.
  - Required: `rsp_zmask`=4'b0011.
  - Stimulus: ADD 0x7FFFFFFF+1 on masked-off lanes only.
  - Required: `rsp_ovf`=0.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 3 cycles with warps 0 and 3 valid.
  - Required: `req_ready`=0 throughout and the response is frozen.
  - Stimulus: raise `rsp_ready`.
  - Required: simultaneous drain and new grant, `rsp_valid` stays 1, no response lost or duplicated.
- Empty mask and idle:
  - Stimulus: warp 0 with mask=0.
  - Required: accepted, response all zeros, `rr_ptr` advances to 1.
  - Stimulus: no requests.
  - Required: `alu_op`=ADD and ALU ports 0 on all lanes, `rsp_valid` drops after drain.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types: ALU opcodes, lane word, warp/thread identifiers and
// the issue-buffer state used by the vector ALU issue arbiter.
package cpu_types_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned NUM_WARPS   = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } aluop_t;

    typedef logic [$clog2(NUM_WARPS)-1:0] warp_id_t;
    typedef logic [NUM_THREADS-1:0]       thread_mask_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } valu_state_t;

endpackage

// File: rtl/valu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping. N must be a power of two so the index add wraps for free.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + IW'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/valu_issue_arbiter.sv
// Round-robin issue of one warp per cycle onto the shared vector ALU, with
// a one-entry masked response buffer under valid/ready backpressure.
module valu_issue_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned THREADS = NUM_THREADS,
    parameter int unsigned WARPS   = NUM_WARPS
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic   [WARPS-1:0]                req_valid,
    output logic   [WARPS-1:0]                req_ready,
    input  aluop_t [WARPS-1:0]                req_op,
    input  word_t  [WARPS-1:0][THREADS-1:0]   req_porta,
    input  word_t  [WARPS-1:0][THREADS-1:0]   req_portb,
    input  logic   [WARPS-1:0][THREADS-1:0]   req_mask,
    output aluop_t [THREADS-1:0]              alu_op,
    output word_t  [THREADS-1:0]              alu_porta,
    output word_t  [THREADS-1:0]              alu_portb,
    input  word_t  [THREADS-1:0]              alu_out,
    input  logic   [THREADS-1:0]              alu_nf,
    input  logic   [THREADS-1:0]              alu_zf,
    input  logic   [THREADS-1:0]              alu_of,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic   [$clog2(WARPS)-1:0]        rsp_warp,
    output word_t  [THREADS-1:0]              rsp_out,
    output logic   [THREADS-1:0]              rsp_mask,
    output logic   [THREADS-1:0]              rsp_zmask,
    output logic   [THREADS-1:0]              rsp_nmask,
    output logic                              rsp_ovf
);

    localparam int unsigned WID_W = $clog2(WARPS);

    valu_state_t          state_q, state_d;
    logic [WID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WID_W-1:0]     rsp_warp_q, rsp_warp_d;
    word_t [THREADS-1:0]  rsp_out_q, rsp_out_d;
    logic [THREADS-1:0]   rsp_mask_q, rsp_mask_d;
    logic [THREADS-1:0]   rsp_zmask_q, rsp_zmask_d;
    logic [THREADS-1:0]   rsp_nmask_q, rsp_nmask_d;
    logic                 rsp_ovf_q, rsp_ovf_d;

    logic                 accept;
    logic                 xfer;
    logic                 gnt_any;
    logic [WARPS-1:0]     gnt;
    logic [WID_W-1:0]     gnt_idx;
    logic [THREADS-1:0]   lane_act;

    rr_arbiter #(.N(WARPS)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_comb begin
        accept    = (state_q == EMPTY) | rsp_ready;
        xfer      = gnt_any & accept;
        req_ready = accept ? gnt : '0;
        lane_act  = xfer ? req_mask[gnt_idx] : '0;
    end

    // Idle and masked-off lanes see ADD 0+0 so their flags are deterministic.
    always_comb begin
        for (int unsigned i = 0; i < THREADS; i++) begin
            alu_op[i]    = lane_act[i] ? req_op[gnt_idx]       : ALU_ADD;
            alu_porta[i] = lane_act[i] ? req_porta[gnt_idx][i] : '0;
            alu_portb[i] = lane_act[i] ? req_portb[gnt_idx][i] : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_warp_d  = rsp_warp_q;
        rsp_out_d   = rsp_out_q;
        rsp_mask_d  = rsp_mask_q;
        rsp_zmask_d = rsp_zmask_q;
        rsp_nmask_d = rsp_nmask_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (xfer) begin
            state_d     = FULL;
            rr_ptr_d    = gnt_idx + WID_W'(1);
            rsp_warp_d  = gnt_idx;
            rsp_mask_d  = lane_act;
            rsp_zmask_d = alu_zf & lane_act;
            rsp_nmask_d = alu_nf & lane_act;
            rsp_ovf_d   = |(alu_of & lane_act);
            for (int unsigned i = 0; i < THREADS; i++) begin
                rsp_out_d[i] = lane_act[i] ? alu_out[i] : '0;
            end
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= EMPTY;
            rr_ptr_q    <= '0;
            rsp_warp_q  <= '0;
            rsp_out_q   <= '0;
            rsp_mask_q  <= '0;
            rsp_zmask_q <= '0;
            rsp_nmask_q <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_warp_q  <= rsp_warp_d;
            rsp_out_q   <= rsp_out_d;
            rsp_mask_q  <= rsp_mask_d;
            rsp_zmask_q <= rsp_zmask_d;
            rsp_nmask_q <= rsp_nmask_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    always_comb begin
        rsp_valid = (state_q == FULL);
        rsp_warp  = rsp_warp_q;
        rsp_out   = rsp_out_q;
        rsp_mask  = rsp_mask_q;
        rsp_zmask = rsp_zmask_q;
        rsp_nmask = rsp_nmask_q;
        rsp_ovf   = rsp_ovf_q;
    end

endmodule
